kypd_key_event: RTL and testbench

Downstream stage of the keypad decoder; sits between the decoder's held 4-bit key code and the LED/display consumers.
- Qualifies each change of the decoded code by a stability window.
- Turns each qualified change into a single key event.
- Buffers events in a small first-word-fall-through FIFO with a valid/ready output.
- Exposes the current stable key.

---
 rtl/kypd_pkg.sv | 21 ++
 rtl/kypd_event_fifo.sv | 75 +++++++
 rtl/kypd_key_event.sv | 130 +++++++++++++
 tb/tb_kypd_key_event.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/kypd_pkg.sv
// kypd_pkg
// Shared definitions for the keypad key-event stage.
//   kypd_state_t          : qualification FSM state encoding
//   KEY_W                 : width of a decoded key code
//   DEFAULT_STABLE_CYCLES : default stability window, 10 ms at 100 MHz
package kypd_pkg;

  localparam int KEY_W = 4;

  // The stability window is expressed in milliseconds of the 100 MHz system clock
  localparam int CLK_MHZ               = 100;
  localparam int STABLE_MS             = 10;
  localparam int DEFAULT_STABLE_CYCLES = STABLE_MS * CLK_MHZ * 1000;

  typedef enum logic [1:0] {
    S_ARM  = 2'd0,
    S_IDLE = 2'd1,
    S_QUAL = 2'd2
  } kypd_state_t;

endpackage

// File: rtl/kypd_event_fifo.sv
// kypd_event_fifo
// Small first-word-fall-through FIFO for event streams. The head entry is
// always presented on pop_data; a push into a full FIFO with no pop in the
// same cycle is dropped and flagged on drop for that cycle.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   push       : write push_data this cycle
//   push_data  : data to write
//   pop        : consume the head this cycle (ignored while empty)
//   pop_data   : head entry
//   empty      : no entries buffered
//   count      : number of buffered entries
//   drop       : a push was discarded because the FIFO was full
module kypd_event_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       drop
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             full;
  logic             pop_ok;
  logic             push_ok;

  assign empty    = (count == '0);
  assign full     = (count == DEPTH_CNT);
  assign pop_data = mem[rd_ptr];

  // A pop frees a slot in the same cycle, so a push into a full FIFO is
  // still accepted when the head is consumed at the same time.
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign drop    = push && full && !pop_ok;

  // Storage, pointers and occupancy; pointers wrap naturally because
  // DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push_ok && !pop_ok) begin
        count <= count + 1'b1;
      end else if (pop_ok && !push_ok) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/kypd_key_event.sv
// kypd_key_event
// Qualifies changes of the held keypad code by a stability window, turns
// each accepted change into one key event and buffers events in a FWFT FIFO.
// Ports:
//   clk        : system clock
//   sys_rst_n  : asynchronous active-low reset
//   code_in    : decoded key code (held value)
//   key_valid  : FIFO head holds an event
//   key_code   : FIFO head event code
//   key_ready  : consumer accepts the head this cycle
//   fifo_count : number of buffered events
//   overflow   : sticky, an event was dropped on a full FIFO
//   last_key   : currently accepted stable code
module kypd_key_event
  import kypd_pkg::*;
#(
  parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                          clk,
  input  logic                          sys_rst_n,
  input  logic [KEY_W-1:0]              code_in,
  output logic                          key_valid,
  output logic [KEY_W-1:0]              key_code,
  input  logic                          key_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic [KEY_W-1:0]              last_key
);

  localparam int CNT_W = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  kypd_state_t      state;
  logic [CNT_W-1:0] counter;
  logic [KEY_W-1:0] code_q;
  logic [KEY_W-1:0] cand;
  logic             fsm_push;
  logic             fifo_empty;
  logic             fifo_drop;

  // Single register stage in front of the FSM; the FSM only ever looks at code_q.
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      code_q <= '0;
    end else begin
      code_q <= code_in;
    end
  end

  // The push strobe is combinational so the event enters the FIFO on the
  // same edge that the FSM accepts the candidate.
  assign fsm_push = (state == S_QUAL) && (code_q != last_key) &&
                    (code_q == cand) && (counter == CNT_MAX);

  // Qualification FSM. In S_ARM, cand doubles as "previous code_q" so the
  // baseline key is learnt without generating an event.
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state    <= S_ARM;
      counter  <= '0;
      cand     <= '0;
      last_key <= '0;
    end else begin
      case (state)
        S_ARM: begin
          if (code_q != cand) begin
            cand    <= code_q;
            counter <= '0;
          end else if (counter == CNT_MAX) begin
            last_key <= code_q;
            state    <= S_IDLE;
          end else begin
            counter <= counter + 1'b1;
          end
        end
        S_IDLE: begin
          if (code_q != last_key) begin
            cand    <= code_q;
            counter <= '0;
            state   <= S_QUAL;
          end
        end
        S_QUAL: begin
          if (code_q == last_key) begin
            state <= S_IDLE;
          end else if (code_q != cand) begin
            cand    <= code_q;
            counter <= '0;
          end else if (counter == CNT_MAX) begin
            last_key <= cand;
            state    <= S_IDLE;
          end else begin
            counter <= counter + 1'b1;
          end
        end
        default: begin
          state <= S_ARM;
        end
      endcase
    end
  end

  kypd_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (KEY_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (sys_rst_n),
    .push      (fsm_push),
    .push_data (cand),
    .pop       (key_ready),
    .pop_data  (key_code),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .drop      (fifo_drop)
  );

  assign key_valid = !fifo_empty;

  // Overflow latches on the first dropped event and is cleared only by reset.
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      overflow <= 1'b0;
    end else if (fifo_drop) begin
      overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_kypd_key_event.sv
// tb_kypd_key_event
// Directed bench for kypd_key_event with an 8-cycle stability window and a
// 4-entry event FIFO.
module tb_kypd_key_event;

  logic       clk;
  logic       sys_rst_n;
  logic [3:0] code_in;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_ready;
  logic [2:0] fifo_count;
  logic       overflow;
  logic [3:0] last_key;

  int errors = 0;
  int checks = 0;

  kypd_key_event #(
    .STABLE_CYCLES (8),
    .FIFO_DEPTH    (4)
  ) dut (
    .clk        (clk),
    .sys_rst_n  (sys_rst_n),
    .code_in    (code_in),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .key_ready  (key_ready),
    .fifo_count (fifo_count),
    .overflow   (overflow),
    .last_key   (last_key)
  );

  // 100 MHz clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive code/ready, then let the given number of rising edges pass;
  // returns 1 time unit after the last edge so outputs can be sampled.
  task automatic applyStimulus(input logic [3:0] code, input logic ready, input int cycles);
    code_in   = code;
    key_ready = ready;
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_valid"},    8'(key_valid),  8'h0);
    checkOutput({tag, "_code"},     8'(key_code),   8'h0);
    checkOutput({tag, "_count"},    8'(fifo_count), 8'h0);
    checkOutput({tag, "_overflow"}, 8'(overflow),   8'h0);
    checkOutput({tag, "_last_key"}, 8'(last_key),   8'h0);
  endtask

  // Pop one event after confirming it is the expected head
  task automatic popExpect(input string tag, input logic [3:0] code);
    checkOutput({tag, "_valid"}, 8'(key_valid), 8'h1);
    checkOutput({tag, "_code"},  8'(key_code),  8'(code));
    applyStimulus(code_in, 1'b1, 1);
    key_ready = 1'b0;
  endtask

  initial begin
    sys_rst_n = 1'b1;
    code_in   = 4'h5;
    key_ready = 1'b0;
    #1 sys_rst_n = 1'b0;
    applyStimulus(4'h5, 1'b0, 2);
    $display("[TB] reset state");
    checkReset("reset");

    // 1. Baseline: learn key 5, no event
    sys_rst_n = 1'b1;
    applyStimulus(4'h5, 1'b0, 14);
    $display("[TB] baseline");
    checkOutput("base_last_key", 8'(last_key),  8'h5);
    checkOutput("base_valid",    8'(key_valid), 8'h0);

    // 2. Clean press: event appears on the 10th edge after the change
    applyStimulus(4'hA, 1'b0, 9);
    $display("[TB] clean press");
    checkOutput("press_early_valid", 8'(key_valid), 8'h0);
    applyStimulus(4'hA, 1'b0, 1);
    checkOutput("press_valid",    8'(key_valid),  8'h1);
    checkOutput("press_code",     8'(key_code),   8'hA);
    checkOutput("press_last_key", 8'(last_key),   8'hA);
    checkOutput("press_count",    8'(fifo_count), 8'h1);
    applyStimulus(4'hA, 1'b1, 1);
    key_ready = 1'b0;
    checkOutput("press_pop_count", 8'(fifo_count), 8'h0);
    checkOutput("press_pop_valid", 8'(key_valid),  8'h0);

    // 3. Bounce between A and 3, then settle on 3
    $display("[TB] bounce");
    applyStimulus(4'h3, 1'b0, 3);
    applyStimulus(4'hA, 1'b0, 3);
    applyStimulus(4'h3, 1'b0, 3);
    applyStimulus(4'hA, 1'b0, 3);
    applyStimulus(4'h3, 1'b0, 12);
    checkOutput("bounce_count",    8'(fifo_count), 8'h1);
    checkOutput("bounce_last_key", 8'(last_key),   8'h3);
    popExpect("bounce_pop", 4'h3);
    checkOutput("bounce_empty", 8'(fifo_count), 8'h0);

    // 4. Short excursion to 7 returns to 3: no event
    $display("[TB] return to old key");
    applyStimulus(4'h7, 1'b0, 4);
    applyStimulus(4'h3, 1'b0, 12);
    checkOutput("ret_count",    8'(fifo_count), 8'h0);
    checkOutput("ret_last_key", 8'(last_key),   8'h3);

    // 5. Overflow: five events into a four-entry FIFO
    $display("[TB] overflow");
    for (int c = 1; c <= 5; c++) begin
      applyStimulus(4'(c), 1'b0, 12);
    end
    checkOutput("ovf_count",    8'(fifo_count), 8'h4);
    checkOutput("ovf_flag",     8'(overflow),   8'h1);
    checkOutput("ovf_last_key", 8'(last_key),   8'h5);
    popExpect("ovf_pop1", 4'h1);
    popExpect("ovf_pop2", 4'h2);
    popExpect("ovf_pop3", 4'h3);
    popExpect("ovf_pop4", 4'h4);
    checkOutput("ovf_drained", 8'(fifo_count), 8'h0);
    checkOutput("ovf_sticky",  8'(overflow),   8'h1);

    // Fresh start so overflow is clear for the full push+pop case
    sys_rst_n = 1'b0;
    applyStimulus(4'h5, 1'b0, 2);
    checkReset("reset2");
    sys_rst_n = 1'b1;
    applyStimulus(4'h5, 1'b0, 14);
    checkOutput("rebase_last_key", 8'(last_key), 8'h5);

    // 6. Full FIFO with a simultaneous push and pop
    $display("[TB] full push+pop");
    for (int c = 1; c <= 4; c++) begin
      applyStimulus(4'(c), 1'b0, 12);
    end
    checkOutput("full_count", 8'(fifo_count), 8'h4);
    applyStimulus(4'h6, 1'b0, 9);
    applyStimulus(4'h6, 1'b1, 1);
    key_ready = 1'b0;
    checkOutput("pp_count",    8'(fifo_count), 8'h4);
    checkOutput("pp_overflow", 8'(overflow),   8'h0);
    checkOutput("pp_last_key", 8'(last_key),   8'h6);
    popExpect("pp_pop1", 4'h2);
    popExpect("pp_pop2", 4'h3);
    popExpect("pp_pop3", 4'h4);
    popExpect("pp_pop4", 4'h6);
    checkOutput("pp_drained", 8'(fifo_count), 8'h0);

    // Reset while qualifying with an event buffered: immediate, no clock edge
    $display("[TB] reset mid-qualification");
    applyStimulus(4'h8, 1'b0, 12);
    checkOutput("pre_rst_count", 8'(fifo_count), 8'h1);
    applyStimulus(4'h9, 1'b0, 4);
    sys_rst_n = 1'b0;
    #1;
    checkReset("async_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
